// File: rtl/input_conditioner.sv
// Synchronises, debounces and edge-detects raw button/switch pins into clean levels,
// press/release pulses and sticky press flags. Optional LONG_PRESS_EN adds long-press pulses.
module input_conditioner #(
  parameter int              N_CH            = 5,
  parameter int              DEBOUNCE_CYCLES = 500000,
  parameter logic [N_CH-1:0] ACTIVE_LOW_MASK = N_CH'(1),
  parameter int              LONG_CYCLES     = 100000000
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [N_CH-1:0] raw_in,
  input  logic [N_CH-1:0] sticky_clr,
  output logic [N_CH-1:0] level_out,
  output logic [N_CH-1:0] press_pulse,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] press_sticky,
  output logic [N_CH-1:0] long_pulse
);

  if (DEBOUNCE_CYCLES < 1) begin : g_bad_debounce
    $error("input_conditioner: DEBOUNCE_CYCLES must be >= 1");
  end
  if (LONG_CYCLES < 2) begin : g_bad_long
    $error("input_conditioner: LONG_CYCLES must be >= 2");
  end

  localparam int             CW       = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam logic [CW-1:0]  CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [N_CH-1:0] sync1, sync2, norm;
  logic [N_CH-1:0] level_next, press_next, release_next;
  logic [CW-1:0]   cnt      [N_CH];
  logic [CW-1:0]   cnt_next [N_CH];

  // Synchronisers reset to the idle pin level so norm reads inactive during and after reset.
  assign norm = sync2 ^ ACTIVE_LOW_MASK;

  // NOTE: every always_comb output gets a default before any branch so no latch is inferred.
  always_comb begin
    level_next = level_out;
    for (int i = 0; i < N_CH; i++) begin
      cnt_next[i] = '0;
      if (norm[i] != level_out[i]) begin
        if (cnt[i] == CNT_LAST) level_next[i] = norm[i];
        else                    cnt_next[i]   = cnt[i] + 1'b1;
      end
    end
  end

  assign press_next   = level_next & ~level_out;
  assign release_next = ~level_next & level_out;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1         <= ACTIVE_LOW_MASK;
      sync2         <= ACTIVE_LOW_MASK;
      level_out     <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      press_sticky  <= '0;
      for (int i = 0; i < N_CH; i++) cnt[i] <= '0;
    end else begin
      sync1         <= raw_in;
      sync2         <= sync1;
      level_out     <= level_next;
      press_pulse   <= press_next;
      release_pulse <= release_next;
      // A clear landing on the press edge or while press_pulse is visible never wins.
      press_sticky  <= (press_sticky & ~sticky_clr) | press_next | press_pulse;
      for (int i = 0; i < N_CH; i++) cnt[i] <= cnt_next[i];
    end
  end

`ifdef LONG_PRESS_EN
  localparam int            HW        = $clog2(LONG_CYCLES) + 1;
  // hold_cnt is 0 on the press edge, so it reaches LONG_CYCLES-1 one edge after HOLD_LAST.
  localparam logic [HW-1:0] HOLD_LAST = HW'(LONG_CYCLES - 2);

  logic [HW-1:0]   hold_cnt [N_CH];
  logic [N_CH-1:0] long_done;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      long_pulse <= '0;
      long_done  <= '0;
      for (int i = 0; i < N_CH; i++) hold_cnt[i] <= '0;
    end else begin
      long_pulse <= '0;
      for (int i = 0; i < N_CH; i++) begin
        if (press_next[i] || !level_next[i]) begin
          hold_cnt[i]  <= '0;
          long_done[i] <= 1'b0;
        end else if (!long_done[i]) begin
          if (hold_cnt[i] == HOLD_LAST) begin
            long_pulse[i] <= 1'b1;
            long_done[i]  <= 1'b1;
          end else begin
            hold_cnt[i] <= hold_cnt[i] + 1'b1;
          end
        end
      end
    end
  end
`else
  assign long_pulse = '0;
`endif

endmodule
